// File: rtl/wb_stage_pipe_if.sv
// wb_stage_pipe_if: MEM-to-WB valid/ready handshake and instruction bundle
interface wb_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    localparam int BOFF_W = (XLEN == 64) ? 3 : 2;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd_addr;
    logic [1:0]        mem_wb_sel;
    logic [XLEN-1:0]   mem_alu_result;
    logic [XLEN-1:0]   mem_pc_plus4;
    logic [2:0]        mem_funct3;
    logic [BOFF_W-1:0] mem_byte_off;
    modport master (
        output mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_alu_result, mem_pc_plus4, mem_funct3, mem_byte_off,
        input  mem_ready
    );
    modport slave (
        input  mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_alu_result, mem_pc_plus4, mem_funct3, mem_byte_off,
        output mem_ready
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MEM/WB register, write-back mux and load extraction; WB_INSTRET_EN adds the retire counter
module wb_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    wb_stage_pipe_if.slave    mem,
    input  logic [XLEN-1:0]   dm_rdata,
    input  logic              dm_rvalid,
    input  logic              flush,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd_addr,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic [63:0]       instret
);
    localparam int BOFF_W = (XLEN == 64) ? 3 : 2;

    typedef enum logic [1:0] {EMPTY = 2'd0, WAIT = 2'd1, COMMIT = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              p_rw_q, p_rw_d;
    logic [REG_AW-1:0] p_rd_q, p_rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [BOFF_W-1:0] off_q, off_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_w;
    logic [XLEN-1:0]   ld_val;
    logic              cap;

    assign mem.mem_ready = state_q != WAIT;
    assign wb_valid      = state_q == COMMIT;
    assign wb_reg_write  = wb_valid && rw_q;
    assign wb_rd_addr    = rd_q;
    assign wb_rd_data    = data_q;

    // pick the addressed byte/half/word from the aligned read word and extend it per the latched load type
    always_comb begin
        ld_b   = 8'(dm_rdata >> {off_q, 3'b000});
        ld_h   = 16'(dm_rdata >> {off_q[BOFF_W-1:1], 4'b0000});
        ld_w   = 32'(dm_rdata >> {off_q >> 2, 5'b00000});
        ld_val = dm_rdata;
        case (f3_q)
            3'b000:  ld_val = XLEN'($signed(ld_b));
            3'b100:  ld_val = XLEN'(ld_b);
            3'b001:  ld_val = XLEN'($signed(ld_h));
            3'b101:  ld_val = XLEN'(ld_h);
            3'b010:  ld_val = (XLEN == 64) ? XLEN'($signed(ld_w)) : dm_rdata;
            3'b110:  ld_val = (XLEN == 64) ? XLEN'(ld_w) : dm_rdata;
            default: ld_val = dm_rdata;
        endcase
    end

    // next state: capture from EMPTY/COMMIT, wait for load data in WAIT; flush only aborts WAIT or blocks capture
    always_comb begin
        state_d = state_q;
        p_rw_d  = p_rw_q;
        p_rd_d  = p_rd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cap     = mem.mem_valid && mem.mem_ready && !flush;
        if (state_q == WAIT) begin
            if (flush) begin
                state_d = EMPTY;
            end else if (dm_rvalid) begin
                state_d = COMMIT;
                rw_d    = p_rw_q && |p_rd_q;
                rd_d    = p_rd_q;
                data_d  = ld_val;
            end
        end else begin
            state_d = EMPTY;
            if (cap) begin
                p_rw_d = mem.mem_reg_write;
                p_rd_d = mem.mem_rd_addr;
                f3_d   = mem.mem_funct3;
                off_d  = mem.mem_byte_off;
                if (mem.mem_wb_sel == 2'b01) begin
                    state_d = WAIT;
                end else begin
                    state_d = COMMIT;
                    rw_d    = mem.mem_reg_write && |mem.mem_rd_addr;
                    rd_d    = mem.mem_rd_addr;
                    data_d  = (mem.mem_wb_sel == 2'b10) ? mem.mem_pc_plus4 : mem.mem_alu_result;
                end
            end
        end
    end

    // MEM/WB pipeline register and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            p_rw_q  <= 1'b0;
            p_rd_q  <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            p_rw_q  <= p_rw_d;
            p_rd_q  <= p_rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // one more retired instruction in every commit cycle, wrapping at 2^64
    always_comb instret_d = instret_q + 64'(wb_valid);

    // retire counter register
    always_ff @(posedge clk) begin
        if (rst) instret_q <= '0;
        else     instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: 32- and 64-bit write-back stages in lockstep against a spec-level model
module tb_wb_stage_pipe;
`ifdef WB_INSTRET_EN
    localparam bit INS = 1'b1;
`else
    localparam bit INS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid, rw_in, rvalid, flush;
    logic [4:0]  rd_in;
    logic [1:0]  sel;
    logic [2:0]  f3, off;
    logic [63:0] alu, pc4, dm;

    logic        wv32, wrw32, wv64, wrw64;
    logic [4:0]  ra32, ra64;
    logic [31:0] rd32;
    logic [63:0] rd64, ir32, ir64;

    int n_vec = 0;
    int n_err = 0;

    // spec-level model: busy = load outstanding, commit = retiring next cycle
    logic        m_busy, m_commit, m_rw, p_rw;
    logic [4:0]  m_rd, p_rd;
    logic [31:0] m_d32;
    logic [63:0] m_d64, m_ir;
    logic [2:0]  p_f3, p_off;

    wb_stage_pipe_if #(.XLEN(32), .REG_AW(5)) bus32 ();
    wb_stage_pipe_if #(.XLEN(64), .REG_AW(5)) bus64 ();

    assign bus32.mem_valid      = valid;
    assign bus32.mem_reg_write  = rw_in;
    assign bus32.mem_rd_addr    = rd_in;
    assign bus32.mem_wb_sel     = sel;
    assign bus32.mem_alu_result = alu[31:0];
    assign bus32.mem_pc_plus4   = pc4[31:0];
    assign bus32.mem_funct3     = f3;
    assign bus32.mem_byte_off   = off[1:0];
    assign bus64.mem_valid      = valid;
    assign bus64.mem_reg_write  = rw_in;
    assign bus64.mem_rd_addr    = rd_in;
    assign bus64.mem_wb_sel     = sel;
    assign bus64.mem_alu_result = alu;
    assign bus64.mem_pc_plus4   = pc4;
    assign bus64.mem_funct3     = f3;
    assign bus64.mem_byte_off   = off;

    wb_stage_pipe #(.XLEN(32), .REG_AW(5)) dut32 (
        .clk(clk), .rst(rst), .mem(bus32), .dm_rdata(dm[31:0]), .dm_rvalid(rvalid), .flush(flush),
        .wb_valid(wv32), .wb_reg_write(wrw32), .wb_rd_addr(ra32), .wb_rd_data(rd32), .instret(ir32)
    );
    wb_stage_pipe #(.XLEN(64), .REG_AW(5)) dut64 (
        .clk(clk), .rst(rst), .mem(bus64), .dm_rdata(dm), .dm_rvalid(rvalid), .flush(flush),
        .wb_valid(wv64), .wb_reg_write(wrw64), .wb_rd_addr(ra64), .wb_rd_data(rd64), .instret(ir64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // load extraction from the load-type table, using plain shifts and two's-complement arithmetic
    function automatic logic [63:0] ext(input int xl, input logic [2:0] t, input logic [2:0] o3, input logic [63:0] d);
        logic [63:0] b, h, w, r;
        int o;
        o = int'(o3) % (xl / 8);
        b = (d >> (8 * o)) & 64'hFF;
        h = (d >> (16 * (o / 2))) & 64'hFFFF;
        w = (d >> (32 * (o / 4))) & 64'hFFFF_FFFF;
        case (t)
            3'b000:  r = (b >= 64'h80) ? b - 64'h100 : b;
            3'b100:  r = b;
            3'b001:  r = (h >= 64'h8000) ? h - 64'h1_0000 : h;
            3'b101:  r = h;
            3'b010:  r = (xl == 64) ? ((w >= 64'h8000_0000) ? w - 64'h1_0000_0000 : w) : d;
            3'b110:  r = (xl == 64) ? w : d;
            default: r = d;
        endcase
        return (xl == 64) ? r : (r & 64'hFFFF_FFFF);
    endfunction

    task automatic check_all();
        chk("ready32", 64'(bus32.mem_ready), 64'(!m_busy));
        chk("ready64", 64'(bus64.mem_ready), 64'(!m_busy));
        chk("valid32", 64'(wv32), 64'(m_commit));
        chk("valid64", 64'(wv64), 64'(m_commit));
        chk("we32", 64'(wrw32), 64'(m_commit && m_rw));
        chk("we64", 64'(wrw64), 64'(m_commit && m_rw));
        chk("addr32", 64'(ra32), 64'(m_rd));
        chk("addr64", 64'(ra64), 64'(m_rd));
        chk("data32", 64'(rd32), 64'(m_d32));
        chk("data64", rd64, m_d64);
        chk("instret32", ir32, INS ? m_ir : 64'd0);
        chk("instret64", ir64, INS ? m_ir : 64'd0);
    endtask

    // advance the model with the inputs now driven, clock once, then compare on the falling edge
    task automatic tick();
        logic [63:0] v;
        if (rst) begin
            {m_busy, m_commit, m_rw, p_rw} = '0;
            m_rd = '0; p_rd = '0; m_d32 = '0; m_d64 = '0; m_ir = '0; p_f3 = '0; p_off = '0;
        end else begin
            if (m_commit) m_ir = m_ir + 64'd1;
            m_commit = 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0;
                end else if (rvalid) begin
                    m_busy   = 1'b0;
                    m_commit = 1'b1;
                    m_rw     = p_rw && (p_rd != 0);
                    m_rd     = p_rd;
                    m_d64    = ext(64, p_f3, p_off, dm);
                    m_d32    = 32'(ext(32, p_f3, p_off, dm & 64'hFFFF_FFFF));
                end
            end else if (valid && !flush) begin
                p_rw = rw_in; p_rd = rd_in; p_f3 = f3; p_off = off;
                if (sel == 2'b01) begin
                    m_busy = 1'b1;
                end else begin
                    v        = (sel == 2'b10) ? pc4 : alu;
                    m_commit = 1'b1;
                    m_rw     = rw_in && (rd_in != 0);
                    m_rd     = rd_in;
                    m_d64    = v;
                    m_d32    = v[31:0];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        {valid, rw_in, rvalid, flush} = '0;
        rd_in = '0; sel = '0; f3 = '0; off = '0; alu = '0; pc4 = '0; dm = '0;
        rst = 1'b1;
        tick();
        chk("rst_ready", 64'(bus32.mem_ready), 64'd1);
        rst = 1'b0;

        // back-to-back ALU results
        valid = 1'b1; sel = 2'b00; rw_in = 1'b1; rd_in = 5'd5; alu = 64'h11;
        tick();
        chk("b2b_first", 64'(rd32), 64'h11);
        rd_in = 5'd6; alu = 64'h22;
        tick();
        chk("b2b_second", 64'(rd32), 64'h22);
        chk("b2b_ready", 64'(bus32.mem_ready), 64'd1);
        valid = 1'b0;
        tick();
        chk("b2b_instret", ir32, INS ? 64'd2 : 64'd0);

        // LB off=3 with data returned three cycles after capture
        valid = 1'b1; sel = 2'b01; f3 = 3'b000; off = 3'd3; rd_in = 5'd7;
        tick();
        valid = 1'b0;
        chk("lb_wait1", 64'(bus32.mem_ready), 64'd0);
        tick();
        chk("lb_wait2", 64'(bus32.mem_ready), 64'd0);
        tick();
        chk("lb_wait3", 64'(bus32.mem_ready), 64'd0);
        dm = 64'h80FF_FF7F; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("lb32", 64'(rd32), 64'hFFFF_FF80);
        chk("lb64", rd64, 64'hFFFF_FFFF_FFFF_FF80);

        // LHU off=2 at minimum latency
        valid = 1'b1; f3 = 3'b101; off = 3'd2;
        tick();
        valid = 1'b0; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("lhu32", 64'(rd32), 64'h0000_80FF);

        // LW / LWU on the upper word of a 64-bit read
        valid = 1'b1; f3 = 3'b010; off = 3'd4;
        tick();
        valid = 1'b0; dm = 64'h8000_0001_0000_0000; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("lw64", rd64, 64'hFFFF_FFFF_8000_0001);
        valid = 1'b1; f3 = 3'b110;
        tick();
        valid = 1'b0; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("lwu64", rd64, 64'h0000_0000_8000_0001);

        // flush wins over dm_rvalid in WAIT
        valid = 1'b1; f3 = 3'b000; off = 3'd0;
        tick();
        valid = 1'b0; flush = 1'b1; rvalid = 1'b1;
        tick();
        flush = 1'b0; rvalid = 1'b0;
        chk("flush_valid", 64'(wv32), 64'd0);
        chk("flush_ready", 64'(bus32.mem_ready), 64'd1);

        // JAL to x0 still retires without writing
        valid = 1'b1; sel = 2'b10; rd_in = 5'd0; rw_in = 1'b1; pc4 = 64'h104;
        tick();
        valid = 1'b0;
        chk("jal_valid", 64'(wv32), 64'd1);
        chk("jal_we", 64'(wrw32), 64'd0);
        chk("jal_data", 64'(rd32), 64'h104);

        // reset in the commit cycle
        valid = 1'b1; sel = 2'b00; rd_in = 5'd9; alu = 64'h55;
        tick();
        valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(wv32), 64'd0);
        chk("rst_data", 64'(rd32), 64'd0);
        chk("rst_instret", ir64, 64'd0);

        // randomized traffic, including resets and flushes at arbitrary points
        for (int i = 0; i < 3000; i++) begin
            rst    = $urandom_range(99) < 2;
            valid  = $urandom_range(9) < 7;
            rw_in  = $urandom_range(3) != 0;
            rd_in  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            sel    = 2'($urandom);
            f3     = 3'($urandom);
            off    = 3'($urandom);
            alu    = {$urandom, $urandom};
            pc4    = {$urandom, $urandom};
            dm     = {$urandom, $urandom};
            rvalid = $urandom_range(9) < 4;
            flush  = $urandom_range(9) == 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Registered, parametrised write-back stage for the 5-stage RISC-V core, placed between MEM and the register file. It holds the MEM/WB pipeline register and selects the write-back source: ALU result, load data or PC+4. It extracts and sign- or zero-extends sub-word load data, and waits for a variable-latency data-memory response using a valid/ready handshake. It drives the register-file write port and the forwarding source.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- BOFF_W, derived (2 when XLEN=32, 3 when XLEN=64), byte-offset width; not user-set.

- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  MEM presents an instruction.
- mem_ready  out  1  WB accepts; transfer when mem_valid && mem_ready.
- mem_reg_write  in  1  instruction writes rd.
- mem_rd_addr  in  REG_AW  destination register.
- mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- mem_alu_result  in  XLEN  ALU result.
- mem_pc_plus4  in  XLEN  link value.
- mem_funct3  in  3  load type.
- mem_byte_off  in  BOFF_W  load address low bits.
- dm_rdata  in  XLEN  aligned data-memory read word.
- dm_rvalid  in  1  dm_rdata valid this cycle.
- flush  in  1  kill the incoming instruction and any pending load.
- wb_valid  out  1  an instruction retires this cycle.
- wb_reg_write  out  1  register-file write enable.
- wb_rd_addr  out  REG_AW  write address.
- wb_rd_data  out  XLEN  write data.
- instret  out  64  retired-instruction count.

## Operation
- State machine with three states: EMPTY, WAIT, COMMIT. Reset state is EMPTY.
- mem_ready is 1 in EMPTY and in COMMIT, and 0 in WAIT.
- Capture (transfer && !flush):
  - A load (wb_sel=01) goes to WAIT.
  - Any other source: the selected value is registered and the state goes to COMMIT.
- In WAIT:
  - dm_rvalid=1: the extracted load value is registered and the state goes to COMMIT.
  - flush=1: the state goes to EMPTY and nothing is written. flush takes priority over a simultaneous dm_rvalid.
- In COMMIT:
  - wb_valid=1.
  - wb_reg_write = captured reg_write && rd != 0.
  - The next state is decided by a new capture exactly as in EMPTY; with no capture it is EMPTY.
- flush never cancels a commit that is already in progress. It only blocks the capture in the same cycle and aborts WAIT.
- dm_rvalid is ignored outside WAIT.
- A retire with rd=x0 still has wb_valid=1 and still counts toward instret, but wb_reg_write=0.
- Load extraction uses mem_funct3 and mem_byte_off, both latched at capture:
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: half at off[BOFF_W-1:1], sign-extended.
  - 101 LHU: half at off[BOFF_W-1:1], zero-extended.
  - 010 LW: word at the offset's word index; sign-extended when XLEN=64.
  - 110 LWU: zero-extended word; XLEN=64 only.
  - 011 LD: XLEN=64 only.
  - Any encoding that is illegal for the configured XLEN passes the full dm_rdata through unchanged.
  - Misaligned low offset bits are ignored (no trap at this stage).
- wb_rd_data, wb_rd_addr and wb_reg_write hold their last values outside COMMIT. In those cycles wb_reg_write is 0.

## Timing
- After reset, all outputs are 0, the state is EMPTY and mem_ready=1.
- Non-load: captured at edge N, committed in cycle N+1. Throughput is one instruction per cycle.
- Load: captured at edge N; dm_rvalid is sampled from cycle N+1 onward. If dm_rvalid is high at edge M, the commit happens in cycle M+1. The minimum load latency is 2 cycles.
- mem_ready depends only on registered state; it has no combinational path from mem_valid.
- A reset asserted mid-WAIT or mid-COMMIT forces EMPTY at the next edge. No write occurs in the cycle after that edge.

## Configuration
- WB_INSTRET_EN defined:
  - instret is a 64-bit counter, cleared by rst, incremented by 1 in every cycle with wb_valid=1.
  - It wraps from 2^64-1 to 0.
- WB_INSTRET_EN undefined: instret is tied to 0 and no counter flops are present.

## Test plan
- Back-to-back ALU ops (rd=5 value 0x11, then rd=6 value 0x22) on consecutive cycles -> commits in consecutive cycles, mem_ready stays 1, instret=2.
- LB, off=3, dm_rdata=0x80FF_FF7F returned 3 cycles after capture -> mem_ready=0 for 3 cycles, then wb_rd_data=0xFFFF_FF80. LHU off=2 on the same word -> 0x0000_80FF.
- XLEN=64: LW, off=4, dm_rdata=0x8000_0001_0000_0000 -> 0xFFFF_FFFF_8000_0001. LWU -> 0x0000_0000_8000_0001.
- Load in WAIT with flush and dm_rvalid in the same cycle -> no wb_valid, state EMPTY, instret unchanged.
- JAL with rd=0, pc_plus4=0x104 -> wb_valid=1, wb_reg_write=0, instret increments (macro defined) or stays 0 (macro undefined).
- rst pulsed in the cycle a commit would occur -> all outputs 0 and mem_ready=1 on the following cycle.
